universal_shift_register: RTL and testbench

Parametrised N-bit universal shift register that extends the 4-bit bidirectional serial shifter with parallel load, rotate, arithmetic shift and clear. It also runs multi-step operations: one start command shifts or rotates by a programmed amount, one position per clock, with a busy/done handshake. It sits in the sequential/registers/shift_registers library. Datapath blocks and serial-link front ends use it when they need a register that both parallel-loads and shifts a programmable amount.

---
 rtl/universal_shift_register.sv | 150 +++++++++++++++
 tb/tb_universal_shift_register.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// N-bit universal shift register: parallel load, clear, logical/arithmetic shift and rotate,
// with multi-step commands that apply one step per clock under a busy/done handshake.
module universal_shift_register #(
  parameter  int N  = 8,
  localparam int AW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  D,
  input  logic          SI_R,
  input  logic          SI_L,
  output logic [N-1:0]  Q,
  output logic          SO_R,
  output logic          SO_L,
  output logic          busy,
  output logic          done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [2:0] M_NOP  = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  localparam logic [AW-1:0] N_AMT   = AW'(N);
  localparam logic [AW-1:0] ONE_AMT = AW'(1);

  state_t        r_state;
  logic [N-1:0]  r_q;
  logic [AW-1:0] r_rem;
  logic [2:0]    r_mode;
  logic          r_busy;
  logic          r_done;

  state_t        w_state_nxt;
  logic [N-1:0]  w_q_nxt;
  logic [AW-1:0] w_rem_nxt;
  logic [2:0]    w_mode_nxt;
  logic          w_done_nxt;
  logic [AW-1:0] w_amt_eff;

  // One single-bit step of a shift/rotate mode; non-stepping modes leave q untouched.
  function automatic logic [N-1:0] f_step(input logic [2:0] m, input logic [N-1:0] q,
                                          input logic si_r, input logic si_l);
    logic [N-1:0] res;
    case (m)
      M_SHR:   res = {si_r, q[N-1:1]};
      M_SHL:   res = {q[N-2:0], si_l};
      M_ROR:   res = {q[0], q[N-1:1]};
      M_ROL:   res = {q[N-2:0], q[N-1]};
      M_ASR:   res = {q[N-1], q[N-1:1]};
      default: res = q;
    endcase
    return res;
  endfunction

  assign w_amt_eff = (amt > N_AMT) ? N_AMT : amt;

  // Next-state, datapath and completion logic.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_rem_nxt   = r_rem;
    w_mode_nxt  = r_mode;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_mode_nxt = mode;
          case (mode)
            M_NOP:  w_done_nxt = 1'b1;
            M_LOAD: begin
              w_q_nxt    = D;
              w_done_nxt = 1'b1;
            end
            M_CLR: begin
              w_q_nxt    = {N{1'b0}};
              w_done_nxt = 1'b1;
            end
            default: begin
              if (w_amt_eff == {AW{1'b0}}) begin
                w_rem_nxt  = {AW{1'b0}};
                w_done_nxt = 1'b1;
              end else begin
                // First step lands on the accepting edge itself.
                w_q_nxt   = f_step(mode, r_q, SI_R, SI_L);
                w_rem_nxt = w_amt_eff - ONE_AMT;
                if (w_amt_eff == ONE_AMT) begin
                  w_done_nxt = 1'b1;
                end else begin
                  w_state_nxt = ST_RUN;
                end
              end
            end
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_q_nxt   = f_step(r_mode, r_q, SI_R, SI_L);
        w_rem_nxt = r_rem - ONE_AMT;
        if (r_rem == ONE_AMT) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any command without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_q     <= {N{1'b0}};
      r_rem   <= {AW{1'b0}};
      r_mode  <= M_NOP;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_rem   <= w_rem_nxt;
      r_mode  <= w_mode_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= w_done_nxt;
    end
  end

  assign Q    = r_q;
  assign SO_R = r_q[0];
  assign SO_L = r_q[N-1];
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (N = 8): vector table, directed
// multi-cycle sequences and a randomized run against an arithmetic reference model.
module tb_universal_shift_register;

  localparam int N    = 8;
  localparam int AW   = 4;
  localparam int MASK = 255;

  logic          clk;
  logic          reset;
  logic          start;
  logic [2:0]    mode;
  logic [AW-1:0] amt;
  logic [N-1:0]  D;
  logic          SI_R;
  logic          SI_L;
  logic [N-1:0]  Q;
  logic          SO_R;
  logic          SO_L;
  logic          busy;
  logic          done;

  int n_pass;
  int n_total;

  universal_shift_register #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .amt(amt), .D(D),
    .SI_R(SI_R), .SI_L(SI_L), .Q(Q), .SO_R(SO_R), .SO_L(SO_L), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    mode;
    logic [AW-1:0] amt;
    logic [N-1:0]  d;
    logic          si_r;
    logic          si_l;
    logic [N-1:0]  exp_q;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_cmd(input logic [2:0] m, input logic [AW-1:0] a, input logic [N-1:0] d,
                         input logic sr, input logic sl);
    start = 1'b1; mode = m; amt = a; D = d; SI_R = sr; SI_L = sl;
  endtask

  task automatic load(input logic [N-1:0] d);
    set_cmd(3'b011, 4'd0, d, 1'b0, 1'b0);
    tick();
    start = 1'b0;
  endtask

  // Issue a command and wait (bounded) for done; reports edges taken and busy cycles seen.
  task automatic issue_wait(input logic [2:0] m, input logic [AW-1:0] a, input logic sr,
                            input logic sl, output int edges, output int busys);
    set_cmd(m, a, 8'h00, sr, sl);
    tick();
    start = 1'b0;
    edges = 1;
    busys = int'(busy);
    while (!done && edges < 40) begin
      tick();
      edges++;
      busys += int'(busy);
    end
  endtask

  // Reference: one step computed with plain integer arithmetic.
  function automatic int ref_step(input int m, input int q, input int sr, input int sl);
    case (m)
      1:       return (q >> 1) | (sr << (N - 1));
      2:       return ((q << 1) | sl) & MASK;
      4:       return (q >> 1) | ((q & 1) << (N - 1));
      5:       return ((q << 1) & MASK) | (q >> (N - 1));
      6:       return (q >> 1) | (q & (1 << (N - 1)));
      default: return q;
    endcase
  endfunction

  int edges, busys;
  int m_q, m_left, m_mode, m_done, m_amt;

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; start = 1'b0; mode = 3'b000; amt = 4'd0; D = 8'h00; SI_R = 1'b0; SI_L = 1'b0;

    // Reset for two cycles.
    tick(); tick();
    check("reset_q", Q, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_so", {SO_L, SO_R}, 2'b00);
    reset = 1'b0;

    // Single-edge commands applied back to back (each accepted while done is high).
    vecs[0] = '{3'b011, 4'd0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    vecs[1] = '{3'b001, 4'd1, 8'h00, 1'b0, 1'b0, 8'h52, 1'b0, 1'b1};
    vecs[2] = '{3'b010, 4'd1, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1};
    vecs[3] = '{3'b100, 4'd1, 8'h00, 1'b0, 1'b0, 8'hD2, 1'b0, 1'b1};
    vecs[4] = '{3'b101, 4'd1, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    vecs[5] = '{3'b110, 4'd1, 8'h00, 1'b0, 1'b0, 8'hD2, 1'b0, 1'b1};
    vecs[6] = '{3'b000, 4'd3, 8'hFF, 1'b1, 1'b1, 8'hD2, 1'b0, 1'b1};
    vecs[7] = '{3'b001, 4'd0, 8'hFF, 1'b1, 1'b1, 8'hD2, 1'b0, 1'b1};
    vecs[8] = '{3'b111, 4'd5, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[9] = '{3'b011, 4'd7, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      set_cmd(vecs[i].mode, vecs[i].amt, vecs[i].d, vecs[i].si_r, vecs[i].si_l);
      tick();
      check($sformatf("vec%0d_q", i), Q, vecs[i].exp_q);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
    end
    start = 1'b0;
    tick();
    check("idle_done_low", done, 1'b0);

    // Streamed right shift by 3 with SI_R = 1.
    load(8'hA5);
    set_cmd(3'b001, 4'd3, 8'h00, 1'b1, 1'b0);
    tick(); start = 1'b0;
    check("shr_s1_q", Q, 8'hD2); check("shr_s1_busy", busy, 1'b1); check("shr_s1_done", done, 1'b0);
    check("shr_s1_sor", SO_R, 1'b0);
    tick();
    check("shr_s2_q", Q, 8'hE9); check("shr_s2_busy", busy, 1'b1); check("shr_s2_done", done, 1'b0);
    check("shr_s2_sor", SO_R, 1'b1);
    tick();
    check("shr_s3_q", Q, 8'hF4); check("shr_s3_busy", busy, 1'b0); check("shr_s3_done", done, 1'b1);
    check("shr_s3_sor", SO_R, 1'b0);
    tick();
    check("shr_after_done", done, 1'b0);

    // Rotates.
    load(8'h3C);
    issue_wait(3'b101, 4'd4, 1'b0, 1'b0, edges, busys);
    check("rol4_q", Q, 8'hC3); check("rol4_edges", edges, 4); check("rol4_busy", busys, 3);
    check("rol4_done", done, 1'b1);
    issue_wait(3'b100, 4'd8, 1'b0, 1'b0, edges, busys);
    check("ror8_q", Q, 8'hC3); check("ror8_edges", edges, 8); check("ror8_busy", busys, 7);
    check("ror8_done", done, 1'b1);

    // Arithmetic right keeps the sign bit.
    load(8'h90);
    set_cmd(3'b110, 4'd2, 8'h00, 1'b0, 1'b0);
    tick(); start = 1'b0;
    check("asr_s1_q", Q, 8'hC8); check("asr_s1_sol", SO_L, 1'b1);
    tick();
    check("asr_s2_q", Q, 8'hE4); check("asr_s2_sol", SO_L, 1'b1); check("asr_s2_done", done, 1'b1);

    // Start while busy is ignored; reset mid-run aborts without done.
    load(8'h01);
    set_cmd(3'b010, 4'd5, 8'h00, 1'b0, 1'b0);
    tick();
    check("abort_s1_q", Q, 8'h02); check("abort_s1_busy", busy, 1'b1);
    set_cmd(3'b011, 4'd0, 8'hFF, 1'b0, 1'b0);
    tick(); start = 1'b0;
    check("abort_ignored_q", Q, 8'h04); check("abort_ignored_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_q", Q, 8'h00); check("abort_busy", busy, 1'b0); check("abort_done", done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_nodone%0d", i), {busy, done}, 2'b00);
      check($sformatf("abort_hold%0d", i), Q, 8'h00);
    end

    // Amount clamp and zero amount.
    load(8'hFF);
    issue_wait(3'b010, 4'd12, 1'b0, 1'b0, edges, busys);
    check("clamp_q", Q, 8'h00); check("clamp_edges", edges, 8); check("clamp_busy", busys, 7);
    check("clamp_done", done, 1'b1);
    load(8'h5A);
    issue_wait(3'b001, 4'd0, 1'b1, 1'b1, edges, busys);
    check("amt0_q", Q, 8'h5A); check("amt0_edges", edges, 1); check("amt0_busy", busys, 0);
    check("amt0_done", done, 1'b1);

    // Randomized run against the reference model.
    m_q = 8'h5A; m_left = 0; m_mode = 0;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 60) == 0);
      start = ($urandom_range(0, 2) != 0);
      mode  = 3'($urandom_range(0, 7));
      amt   = 4'($urandom_range(0, 15));
      D     = 8'($urandom_range(0, 255));
      SI_R  = 1'($urandom_range(0, 1));
      SI_L  = 1'($urandom_range(0, 1));
      m_done = 0;
      if (reset) begin
        m_q = 0; m_left = 0; m_mode = 0;
      end else if (m_left > 0) begin
        m_q = ref_step(m_mode, m_q, int'(SI_R), int'(SI_L));
        m_left--;
        if (m_left == 0) m_done = 1;
      end else if (start) begin
        m_mode = int'(mode);
        m_amt  = (int'(amt) > N) ? N : int'(amt);
        if (m_mode == 3) m_q = int'(D);
        else if (m_mode == 7) m_q = 0;
        if (m_mode == 0 || m_mode == 3 || m_mode == 7 || m_amt == 0) begin
          m_done = 1;
        end else begin
          m_q = ref_step(m_mode, m_q, int'(SI_R), int'(SI_L));
          m_left = m_amt - 1;
          if (m_left == 0) m_done = 1;
        end
      end
      tick();
      check($sformatf("rnd%0d_q", c), Q, 32'(m_q));
      check($sformatf("rnd%0d_busy", c), busy, 32'(m_left > 0));
      check($sformatf("rnd%0d_done", c), done, 32'(m_done));
      check($sformatf("rnd%0d_so", c), {SO_L, SO_R}, 32'({m_q[7], m_q[0]}));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
